// File: rtl/mem_load_store_unit_pkg.sv
// Shared load/store unit definitions: instruction type codes, bus widths and FSM state type.
// Type codes above SW are left unused so illegal request types can be detected.
package mem_load_store_unit_pkg;

    localparam int INST_TYPE_WIDTH = 4;
    localparam int DATA_WIDTH      = 32;

    localparam logic [INST_TYPE_WIDTH-1:0] LB  = 4'd0;
    localparam logic [INST_TYPE_WIDTH-1:0] LH  = 4'd1;
    localparam logic [INST_TYPE_WIDTH-1:0] LW  = 4'd2;
    localparam logic [INST_TYPE_WIDTH-1:0] LBU = 4'd3;
    localparam logic [INST_TYPE_WIDTH-1:0] LHU = 4'd4;
    localparam logic [INST_TYPE_WIDTH-1:0] SB  = 4'd5;
    localparam logic [INST_TYPE_WIDTH-1:0] SH  = 4'd6;
    localparam logic [INST_TYPE_WIDTH-1:0] SW  = 4'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } lsu_state_e;

    function automatic logic is_load(input logic [INST_TYPE_WIDTH-1:0] t);
        return (t == LB) || (t == LH) || (t == LW) || (t == LBU) || (t == LHU);
    endfunction

    function automatic logic is_store(input logic [INST_TYPE_WIDTH-1:0] t);
        return (t == SB) || (t == SH) || (t == SW);
    endfunction

endpackage

// File: rtl/mem_load_store_unit_if.sv
// Request, byte-wide memory and response signals of the load/store unit.
// The slave modport is the unit itself; master is the pipeline/memory side.
interface mem_load_store_unit_if #(parameter int ADDR_WIDTH = 32);
    import mem_load_store_unit_pkg::*;

    logic                       req_valid;
    logic                       req_ready;
    logic [INST_TYPE_WIDTH-1:0] req_type;
    logic [ADDR_WIDTH-1:0]      req_addr;
    logic [DATA_WIDTH-1:0]      req_wdata;

    logic [ADDR_WIDTH-1:0]      mem_a;
    logic [7:0]                 mem_dout;
    logic [7:0]                 mem_din;
    logic                       mem_wr;

    logic                       resp_valid;
    logic [INST_TYPE_WIDTH-1:0] resp_type;
    logic [DATA_WIDTH-1:0]      resp_data;

    modport slave (
        input  req_valid, req_type, req_addr, req_wdata, mem_din,
        output req_ready, mem_a, mem_dout, mem_wr, resp_valid, resp_type, resp_data
    );

    modport master (
        output req_valid, req_type, req_addr, req_wdata, mem_din,
        input  req_ready, mem_a, mem_dout, mem_wr, resp_valid, resp_type, resp_data
    );

endinterface

// File: rtl/mem_load_store_unit.sv
// Byte-serial load/store unit in front of a synchronous byte-wide RAM.
// state | meaning
// IDLE  | waiting for a request, req_ready may be high
// LOAD  | issuing read addresses, capturing returned bytes one cycle later
// STORE | writing one byte per cycle
// DONE  | one-cycle response, then back to IDLE
module mem_load_store_unit
    import mem_load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic flush,
    mem_load_store_unit_if.slave bus
);

    lsu_state_e                 state_q;
    logic [2:0]                 cnt_q;
    logic [INST_TYPE_WIDTH-1:0] type_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [DATA_WIDTH-1:0]      data_q;

    logic [2:0] nbytes;
    logic [1:0] cur_idx;
    logic [1:0] prev_idx;
    logic       accept;

    always_comb begin
        case (type_q)
            LB, LBU, SB: nbytes = 3'd1;
            LH, LHU, SH: nbytes = 3'd2;
            default:     nbytes = 3'd4;
        endcase
    end

    assign cur_idx  = cnt_q[1:0];
    assign prev_idx = cur_idx - 2'd1;

    assign bus.req_ready  = (state_q == IDLE) & rdy & ~flush;
    assign accept         = bus.req_valid & bus.req_ready;
    assign bus.resp_valid = (state_q == DONE) & rdy & ~(flush & is_load(type_q));
    assign bus.resp_type  = type_q;
    assign bus.resp_data  = data_q;

    always_comb begin
        bus.mem_a    = '0;
        bus.mem_dout = '0;
        bus.mem_wr   = 1'b0;
        case (state_q)
            LOAD: begin
                // While paused, re-read the previous byte so mem_din still holds it on resume.
                if (!rdy && cnt_q != 3'd0) begin
                    bus.mem_a = addr_q + ADDR_WIDTH'(cnt_q - 3'd1);
                end else if (cnt_q < nbytes) begin
                    bus.mem_a = addr_q + ADDR_WIDTH'(cnt_q);
                end
            end
            STORE: begin
                bus.mem_a    = addr_q + ADDR_WIDTH'(cnt_q);
                bus.mem_dout = wdata_q[{cur_idx, 3'b000} +: 8];
                bus.mem_wr   = rdy;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (accept && (is_load(bus.req_type) || is_store(bus.req_type))) begin
                        type_q  <= bus.req_type;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        data_q  <= '0;
                        cnt_q   <= 3'd0;
                        state_q <= is_load(bus.req_type) ? LOAD : STORE;
                    end
                end
                LOAD: begin
                    if (flush) begin
                        state_q <= IDLE;
                        cnt_q   <= 3'd0;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            data_q[{prev_idx, 3'b000} +: 8] <= bus.mem_din;
                        end
                        if (cnt_q == nbytes) begin
                            state_q <= DONE;
                            cnt_q   <= 3'd0;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                STORE: begin
                    if (cnt_q == nbytes - 3'd1) begin
                        state_q <= DONE;
                        cnt_q   <= 3'd0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Self-checking bench for mem_load_store_unit: byte RAM model plus a transaction-level reference.
module tb_mem_load_store_unit;
    import mem_load_store_unit_pkg::*;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rdy   = 1'b1;
    logic flush = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    mem_load_store_unit_if #(.ADDR_WIDTH(32)) bus();

    mem_load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] ram       [logic [31:0]];
    logic [7:0] model_mem [logic [31:0]];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : dflt(a);
    endfunction

    function automatic int tb_nbytes(input logic [3:0] t);
        case (t)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    // synchronous RAM: read data for the address of cycle t appears in cycle t+1
    always @(posedge clk) begin
        logic [7:0] rd;
        rd = ram_rd(bus.mem_a);
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
        bus.mem_din <= rd;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a]       = b;
        model_mem[a] = b;
    endtask

    task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                         output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    // One transaction checked cycle by cycle; s counts samples after the acceptance edge,
    // act counts only the samples where the unit was allowed to advance.
    task automatic run_txn(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                           input int p_start, input int p_len, input int fl_at);
        int n, lat, act;
        bit ld, st, over, ok, r, f;
        logic [31:0] exp_data;
        n   = tb_nbytes(t);
        ld  = (t == LB) || (t == LH) || (t == LW) || (t == LBU) || (t == LHU);
        st  = (t == SB) || (t == SH) || (t == SW);
        lat = ld ? n + 1 : (st ? n : 2);
        exp_data = '0;
        for (int i = 0; i < n; i++) exp_data[8*i +: 8] = model_rd(a + 32'(i));
        issue(t, a, wd, ok);
        if (!ok) return;
        over = !(ld || st);
        act  = 0;
        for (int s = 0; s < lat + p_len + 3; s++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            r = !(p_len > 0 && s >= p_start && s < p_start + p_len);
            f = (s == fl_at);
            rdy   = r;
            flush = f;
            #1;
            if (over) begin
                chk("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
                chk("idle_mem_wr", 32'(bus.mem_wr), 32'd0);
                if (r && !f) begin
                    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
                    chk("idle_mem_a", bus.mem_a, 32'd0);
                end
            end else if (!r) begin
                chk("pause_mem_wr", 32'(bus.mem_wr), 32'd0);
                chk("pause_resp_valid", 32'(bus.resp_valid), 32'd0);
            end else begin
                if (act < n) begin
                    chk("mem_wr", 32'(bus.mem_wr), st ? 32'd1 : 32'd0);
                    chk("mem_a", bus.mem_a, a + 32'(act));
                    if (st) chk("mem_dout", 32'(bus.mem_dout), 32'(wd[8*act +: 8]));
                end
                if (act == lat) begin
                    chk("resp_valid", 32'(bus.resp_valid), (ld && f) ? 32'd0 : 32'd1);
                    if (!(ld && f)) begin
                        chk("resp_type", 32'(bus.resp_type), 32'(t));
                        if (ld) chk("resp_data", bus.resp_data, exp_data);
                    end
                    over = 1'b1;
                end else begin
                    chk("early_resp_valid", 32'(bus.resp_valid), 32'd0);
                end
                if (ld && f) over = 1'b1;
                act++;
            end
        end
        if (!over) chk("resp_timeout", 32'd0, 32'd1);
        rdy   = 1'b1;
        flush = 1'b0;
        if (st) begin
            for (int i = 0; i < n; i++) model_mem[a + 32'(i)] = wd[8*i +: 8];
            for (int i = 0; i <= n; i++)
                chk("ram_byte", 32'(ram_rd(a + 32'(i))), 32'(model_rd(a + 32'(i))));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        bus.req_valid = 1'b0;
        bus.req_type  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        #2;
        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_type", 32'(bus.resp_type), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        preload(32'h100, 8'h78); preload(32'h101, 8'h56);
        preload(32'h102, 8'h34); preload(32'h103, 8'h12);
        run_txn(LW, 32'h100, 32'h0, 0, 0, -1);

        preload(32'h3, 8'h80);
        run_txn(LB, 32'h3, 32'h0, 0, 0, -1);

        preload(32'h1002, 8'h77);
        run_txn(SH, 32'h1000, 32'hAABBCCDD, 0, 0, -1);
        chk("sh_neighbor", 32'(ram_rd(32'h1002)), 32'h77);

        run_txn(LW, 32'h100, 32'h0, 0, 0, 2);
        run_txn(SW, 32'h2000, 32'h11223344, 0, 0, 2);
        run_txn(LH, 32'hFFFF_FFFF, 32'h0, 1, 3, -1);
        run_txn(LB, 32'h5, 32'h0, 0, 0, 2);
        run_txn(4'hC, 32'h40, 32'h0, 0, 0, -1);

        // request coinciding with flush must not be taken
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_type  = LW;
        bus.req_addr  = 32'h100;
        flush = 1'b1;
        #1;
        chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("flush_no_resp", 32'(bus.resp_valid), 32'd0);
            chk("flush_idle_ready", 32'(bus.req_ready), 32'd1);
            @(negedge clk);
        end

        // reset in the middle of a word store
        issue(SW, 32'h300, 32'hDEADBEEF, ok);
        if (ok) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("midrst_mem_wr", 32'(bus.mem_wr), 32'd0);
            chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("midrst_mem_a", bus.mem_a, 32'd0);
            chk("midrst_idle", 32'(bus.req_ready), 32'd1);
            model_mem[32'h300] = 8'hEF;
            model_mem[32'h301] = 8'hBE;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("postrst_ready", 32'(bus.req_ready), 32'd1);
            chk("midrst_byte2", 32'(ram_rd(32'h302)), 32'(model_rd(32'h302)));
            run_txn(LW, 32'h300, 32'h0, 0, 0, -1);
        end

        for (int k = 0; k < 60; k++) begin
            logic [3:0]  t;
            logic [31:0] a, wd;
            int ps, pl, l;
            t  = 4'($urandom_range(0, 9));
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                             : 32'h400 + 32'($urandom_range(0, 15));
            wd = $urandom;
            ps = 0;
            pl = 0;
            l  = tb_nbytes(t);
            if (l != 0 && $urandom_range(0, 3) == 0) begin
                pl = $urandom_range(1, 3);
                ps = $urandom_range(0, (t <= LHU) ? l + 1 : l);
            end
            run_txn(t, a, wd, ps, pl, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
